demux8x8_collector: RTL and testbench
=====================================

DEMUX8X8_COLLECTOR -- requirements
Module: demux8x8_collector

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits; all data ports and out_k registers SHALL use WIDTH.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers in_data this cycle.
REQ-005 in_ready  output  1  block accepts a word this cycle; transfer occurs when in_valid & in_ready at a rising clk edge.
REQ-006 in_data  input  WIDTH  word to route.
REQ-007 in_sel  input  3  destination slot (0-7), used only when mode=0.
REQ-008 mode  input  1  0 = addressed (slot = in_sel), 1 = sequential (slot = ptr); sampled per transfer.
REQ-009 read_ack  input  1  consumer has taken the complete frame.
REQ-010 out_0 .. out_7  output  WIDTH each  slot registers, held stable between writes.
REQ-011 frame_valid  output  1  all 8 slots written since last release; outputs form a complete frame.
REQ-012 written  output  8  bit k = slot k written in current frame.
REQ-013 ptr  output  3  next slot for sequential mode.

Function
REQ-014 Two states SHALL exist: FILL and FULL; in_ready SHALL equal (state==FILL), frame_valid SHALL equal (state==FULL), both as combinational decodes of registered state.
REQ-015 In FILL, a transfer SHALL write in_data into out_s (s = ptr if mode=1, else in_sel), set written[s], and leave every other slot unchanged.
REQ-016 The written value SHALL be visible on out_s in the cycle after the capturing edge (latency 1).
REQ-017 A mode=1 transfer SHALL increment ptr modulo 8 (7 wraps to 0); a mode=0 transfer SHALL leave ptr unchanged.
REQ-018 A mode=0 transfer to an already-written slot SHALL overwrite out_s; written[s] stays 1; no error indication.
REQ-019 When a transfer makes written equal 8'hFF, state SHALL go to FULL on the same edge, so frame_valid=1 and in_ready=0 from the next cycle.
REQ-020 In FULL, in_valid SHALL be ignored, and out_0..out_7, written and ptr SHALL hold.
REQ-021 In FULL, read_ack=1 at an edge SHALL clear written to 0 and ptr to 0, and return to FILL; out_k SHALL retain their values.
REQ-022 read_ack SHALL have no effect in FILL.
REQ-023 Mixed-mode frames are legal: written tracks slots regardless of mode; ptr advances only on mode=1 transfers.
REQ-024 Minimum frame turnaround SHALL be 8 transfer cycles + 1 FULL cycle with read_ack held high; no combinational path from in_valid/read_ack to in_ready.

Reset
REQ-025 While reset=1, asynchronously: state=FILL, out_0..out_7=0, written=0, ptr=0, frame_valid=0, in_ready=1; no transfer SHALL be captured while reset=1.
REQ-026 Reset asserted mid-frame or in FULL SHALL discard the partial or complete frame, with no residual written bits.
REQ-027 First transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-028 Sequential fill: reset; mode=1, in_valid=1 for 8 cycles, data 8'h10..8'h17 -> out_k=8'h10+k, ptr wraps to 0, frame_valid=1 in cycle 9, in_ready=0.
REQ-029 Addressed fill out of order: mode=0, slots 7,0,3,3,1,2,4,5,6 with data A0..A8 -> out_3=A3 (overwrite), frame_valid rises only after the 9th transfer, written=8'hFF.
REQ-030 Backpressure: in FULL, drive in_valid=1 with 8'hEE for 3 cycles -> no out_k changes; then read_ack=1 for one cycle -> next cycle frame_valid=0, in_ready=1, written=0, ptr=0, out_k unchanged.
REQ-031 Mid-frame reset: write 4 slots with mode=1, assert reset asynchronously between edges -> all out_k=0, written=0, ptr=0 immediately; after release, 8 fresh writes are needed before frame_valid=1.
REQ-032 Mixed mode and wrap: mode=1 writes slots 0-5, mode=0 writes in_sel=7, mode=1 writes once -> slot 6 filled, ptr=7, frame_valid=1 next cycle.
REQ-033 read_ack in FILL: assert read_ack with written=8'h0F -> written, ptr and state unchanged.

Source files
------------

// File: rtl/demux8x8_collector.sv
// demux8x8_collector
//   Collects eight WIDTH-bit words into slot registers out_0..out_7.
//   Each word is routed either to the slot named by in_sel (mode=0) or to the
//   slot named by the internal pointer ptr (mode=1). Once all eight slots have
//   been written, the frame is held until read_ack releases it.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    producer offers in_data
//   in_ready    block can accept a word (decoded from FILL state)
//   in_data     word to route
//   in_sel      destination slot in addressed mode
//   mode        0 = addressed (in_sel), 1 = sequential (ptr)
//   read_ack    consumer has taken the complete frame
//   out_0..7    slot registers
//   frame_valid all eight slots written (decoded from FULL state)
//   written     per-slot written flags for the current frame
//   ptr         next slot for sequential mode
module demux8x8_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             mode,
  input  logic             read_ack,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [WIDTH-1:0] out_5,
  output logic [WIDTH-1:0] out_6,
  output logic [WIDTH-1:0] out_7,
  output logic             frame_valid,
  output logic [7:0]       written,
  output logic [2:0]       ptr
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_slot [8];
  logic [7:0]       r_written;
  logic [7:0]       w_written_nxt;
  logic [7:0]       w_slot_mask;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_nxt;
  logic [2:0]       w_slot;
  logic             w_xfer;
  logic             w_release;

  always_comb begin
    w_slot        = mode ? r_ptr : in_sel;
    w_slot_mask   = 8'd1 << w_slot;
    w_xfer        = in_valid && (r_state == S_FILL);
    w_release     = read_ack && (r_state == S_FULL);
    w_state_nxt   = r_state;
    w_written_nxt = r_written;
    w_ptr_nxt     = r_ptr;
    if (w_xfer) begin
      w_written_nxt = r_written | w_slot_mask;
      if (mode) begin
        w_ptr_nxt = r_ptr + 3'd1;
      end
      // Go FULL on the same edge as the last missing slot is written.
      if (w_written_nxt == '1) begin
        w_state_nxt = S_FULL;
      end
    end else if (w_release) begin
      w_written_nxt = '0;
      w_ptr_nxt     = '0;
      w_state_nxt   = S_FILL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_written <= '0;
      r_ptr     <= '0;
    end else begin
      r_written <= w_written_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_xfer) begin
      r_slot[w_slot] <= in_data;
    end
  end

  assign in_ready    = (r_state == S_FILL);
  assign frame_valid = (r_state == S_FULL);
  assign written     = r_written;
  assign ptr         = r_ptr;
  assign out_0       = r_slot[0];
  assign out_1       = r_slot[1];
  assign out_2       = r_slot[2];
  assign out_3       = r_slot[3];
  assign out_4       = r_slot[4];
  assign out_5       = r_slot[5];
  assign out_6       = r_slot[6];
  assign out_7       = r_slot[7];

endmodule

// File: tb/tb_demux8x8_collector.sv
// tb_demux8x8_collector
//   Self-checking bench for demux8x8_collector (WIDTH=8): a table of addressed
//   writes, hand-written multi-cycle sequences, and random traffic compared
//   against a slot/flag reference model.
module tb_demux8x8_collector;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       mode;
  logic       read_ack;
  logic [7:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
  logic       frame_valid;
  logic [7:0] written;
  logic [2:0] ptr;
  logic [7:0] tb_out [8];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame contents, set of written slots, pointer, full flag
  logic [7:0] m_out [8];
  bit         m_wr  [8];
  int         m_ptr;
  bit         m_full;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] exp_written;
    logic       exp_fv;
  } vec_t;
  vec_t tbl [9];

  demux8x8_collector #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode(mode), .read_ack(read_ack),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_4(out_4), .out_5(out_5), .out_6(out_6), .out_7(out_7),
    .frame_valid(frame_valid), .written(written), .ptr(ptr)
  );

  assign tb_out[0] = out_0;
  assign tb_out[1] = out_1;
  assign tb_out[2] = out_2;
  assign tb_out[3] = out_3;
  assign tb_out[4] = out_4;
  assign tb_out[5] = out_5;
  assign tb_out[6] = out_6;
  assign tb_out[7] = out_7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_out[k] = 8'h00;
      m_wr[k]  = 1'b0;
    end
    m_ptr  = 0;
    m_full = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic md, input logic [2:0] sl,
                                     input logic [7:0] d, input logic ack);
    int  s;
    bit  all;
    if (!m_full) begin
      if (v) begin
        s = md ? m_ptr : int'(sl);
        m_out[s] = d;
        m_wr[s]  = 1'b1;
        if (md) m_ptr = (m_ptr + 1) % 8;
        all = 1'b1;
        for (int k = 0; k < 8; k++) if (!m_wr[k]) all = 1'b0;
        m_full = all;
      end
    end else if (ack) begin
      for (int k = 0; k < 8; k++) m_wr[k] = 1'b0;
      m_ptr  = 0;
      m_full = 1'b0;
    end
  endfunction

  task automatic check_all();
    logic [7:0] w;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("out_%0d", k), {24'd0, tb_out[k]}, {24'd0, m_out[k]});
      w[k] = m_wr[k];
    end
    chk("written", {24'd0, written}, {24'd0, w});
    chk("ptr", {29'd0, ptr}, m_ptr);
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_full});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
  endtask

  // Called #1 after a rising edge; drives inputs, crosses one edge, checks.
  task automatic cyc(input logic v, input logic md, input logic [2:0] sl,
                     input logic [7:0] d, input logic ack);
    in_valid = v; mode = md; in_sel = sl; in_data = d; read_ack = ack;
    @(posedge clk);
    #1;
    model_step(v, md, sl, d, ack);
    check_all();
  endtask

  initial begin
    tbl[0] = '{3'd7, 8'hA0, 8'h80, 1'b0};
    tbl[1] = '{3'd0, 8'hA1, 8'h81, 1'b0};
    tbl[2] = '{3'd3, 8'hA2, 8'h89, 1'b0};
    tbl[3] = '{3'd3, 8'hA3, 8'h89, 1'b0};
    tbl[4] = '{3'd1, 8'hA4, 8'h8B, 1'b0};
    tbl[5] = '{3'd2, 8'hA5, 8'h8F, 1'b0};
    tbl[6] = '{3'd4, 8'hA6, 8'h9F, 1'b0};
    tbl[7] = '{3'd5, 8'hA7, 8'hBF, 1'b0};
    tbl[8] = '{3'd6, 8'hA8, 8'hFF, 1'b1};

    reset = 1'b1; in_valid = 1'b1; mode = 1'b1; in_sel = 3'd0;
    in_data = 8'h55; read_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Sequential fill, first transfer on the first edge after reset
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 3'd0, 8'h10 + 8'(k), 1'b0);
    for (int k = 0; k < 8; k++) chk("seq_out", {24'd0, tb_out[k]}, 32'h10 + k);
    chk("seq_fv", {31'd0, frame_valid}, 32'd1);
    chk("seq_ready", {31'd0, in_ready}, 32'd0);
    chk("seq_ptr_wrap", {29'd0, ptr}, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

    // Addressed out-of-order fill from the table
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, tbl[i].sel, tbl[i].data, 1'b0);
      chk($sformatf("tbl_written_%0d", i), {24'd0, written}, {24'd0, tbl[i].exp_written});
      chk($sformatf("tbl_fv_%0d", i), {31'd0, frame_valid}, {31'd0, tbl[i].exp_fv});
    end
    chk("tbl_out3_overwrite", {24'd0, out_3}, 32'hA3);

    // Backpressure in FULL, then release
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'(i), 8'hEE, 1'b0);
    chk("bp_out7", {24'd0, out_7}, 32'hA0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("rel_fv", {31'd0, frame_valid}, 32'd0);
    chk("rel_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_written", {24'd0, written}, 32'd0);
    chk("rel_ptr", {29'd0, ptr}, 32'd0);
    chk("rel_out6", {24'd0, out_6}, 32'hA8);

    // read_ack in FILL has no effect
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 3'd0, 8'h30 + 8'(k), 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("ackfill_written", {24'd0, written}, 32'h0F);
    chk("ackfill_ptr", {29'd0, ptr}, 32'd4);
    chk("ackfill_ready", {31'd0, in_ready}, 32'd1);

    // Mid-frame asynchronous reset, held across an edge with in_valid high
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_out0", {24'd0, out_0}, 32'd0);
    in_valid = 1'b1; mode = 1'b1; in_data = 8'h77;
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 3'd0, 8'h40 + 8'(k), 1'b0);
      chk($sformatf("fresh_fv_%0d", k), {31'd0, frame_valid}, (k == 7) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

    // Mixed mode: sequential 0-5, addressed 7, sequential once more fills 6
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 3'd0, 8'h60 + 8'(k), 1'b0);
    cyc(1'b1, 1'b0, 3'd7, 8'h67, 1'b0);
    chk("mix_fv_pre", {31'd0, frame_valid}, 32'd0);
    cyc(1'b1, 1'b1, 3'd0, 8'h66, 1'b0);
    chk("mix_out6", {24'd0, out_6}, 32'h66);
    chk("mix_ptr", {29'd0, ptr}, 32'd7);
    chk("mix_fv", {31'd0, frame_valid}, 32'd1);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
          8'($urandom), ($urandom_range(2, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
